pc_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the program counter datapath. It issues instruction fetches and waits for the memory handshake. It classifies each instruction's control-flow type and drives the PC write-enable and next-PC select lines at the correct cycle. It also detects halt, illegal-class, misaligned-target and fetch-timeout conditions, and maintains a retired-instruction counter.

---
 rtl/pc_sequencer.sv | 164 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Multi-cycle program-counter sequencer: fetch handshake, decode, execute with stall,
// PC update with select lines, halt/resume, sticky fault reporting and retire counting.
module pc_sequencer #(
  parameter int unsigned BOOT_DELAY    = 2,
  parameter int unsigned FETCH_TIMEOUT = 15,
  parameter int unsigned COUNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               imem_ack,
  input  logic [2:0]         instr_class,
  input  logic               branch_taken,
  input  logic               stall,
  input  logic [1:0]         target_lsb,
  input  logic               resume,
  output logic               imem_req,
  output logic               ir_wren,
  output logic               exec_en,
  output logic               pc_wren,
  output logic               pc_alu_sel,
  output logic               pc_next_sel,
  output logic               retire,
  output logic               halted,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int unsigned BW = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY + 1) : 1;
  localparam int unsigned TW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;

  localparam logic [2:0] C_SEQ    = 3'd0;
  localparam logic [2:0] C_BRANCH = 3'd1;
  localparam logic [2:0] C_JAL    = 3'd2;
  localparam logic [2:0] C_JALR   = 3'd3;
  localparam logic [2:0] C_HALT   = 3'd4;

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_UPDATE, S_HALT, S_FAULT
  } state_t;

  state_t         state, state_n;
  logic [BW-1:0]  boot_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic [2:0]     cls_q;
  logic           taken_q;
  logic           fault_set;
  logic [1:0]     code_n;
  logic [1:0]     upd_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_BOOT;
      boot_cnt    <= '0;
      tmo_cnt     <= '0;
      cls_q       <= C_SEQ;
      taken_q     <= 1'b0;
      instr_count <= '0;
      fault       <= 1'b0;
      fault_code  <= 2'd0;
    end else begin
      state <= state_n;
      if (state == S_BOOT)
        boot_cnt <= boot_cnt + BW'(1);
      if (state == S_FETCH && state_n == S_FETCH)
        tmo_cnt <= tmo_cnt + TW'(1);
      else
        tmo_cnt <= '0;
      if (state == S_DECODE)
        cls_q <= instr_class;
      if (state == S_EXEC && !stall)
        taken_q <= branch_taken;
      if (retire)
        instr_count <= instr_count + COUNT_W'(1);
      if (fault_set && !fault) begin
        fault      <= 1'b1;
        fault_code <= code_n;
      end
    end
  end

  // {alu_sel, next_sel} derived from the class/taken captured for this instruction
  always_comb begin
    upd_sel = 2'b10;
    case (cls_q)
      C_SEQ:    upd_sel = 2'b10;
      C_BRANCH: upd_sel = taken_q ? 2'b00 : 2'b10;
      C_JAL:    upd_sel = 2'b00;
      C_JALR:   upd_sel = 2'b11;
      default:  upd_sel = 2'b10;
    endcase
  end

  always_comb begin
    state_n     = state;
    imem_req    = 1'b0;
    ir_wren     = 1'b0;
    exec_en     = 1'b0;
    pc_wren     = 1'b0;
    pc_alu_sel  = 1'b0;
    pc_next_sel = 1'b0;
    retire      = 1'b0;
    halted      = 1'b0;
    fault_set   = 1'b0;
    code_n      = 2'd0;
    case (state)
      S_BOOT: begin
        if (boot_cnt == BW'(BOOT_DELAY - 1))
          state_n = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_wren = 1'b1;
          state_n = S_DECODE;
        end else if (tmo_cnt == TW'(FETCH_TIMEOUT - 1)) begin
          state_n   = S_FAULT;
          fault_set = 1'b1;
          code_n    = 2'd3;
        end
      end
      S_DECODE: begin
        if (instr_class > C_HALT) begin
          state_n   = S_FAULT;
          fault_set = 1'b1;
          code_n    = 2'd1;
        end else if (instr_class == C_HALT) begin
          retire  = 1'b1;
          state_n = S_HALT;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        exec_en = 1'b1;
        if (!stall)
          state_n = S_UPDATE;
      end
      S_UPDATE: begin
        {pc_alu_sel, pc_next_sel} = upd_sel;
        if (target_lsb != 2'd0) begin
          state_n   = S_FAULT;
          fault_set = 1'b1;
          code_n    = 2'd2;
        end else begin
          pc_wren = 1'b1;
          retire  = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) begin
          pc_wren    = 1'b1;
          pc_alu_sel = 1'b1;
          state_n    = S_FETCH;
        end
      end
      S_FAULT: state_n = S_FAULT;
      default: state_n = S_BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: scenarios are expanded into per-cycle stimulus and
// expected outputs by a transaction-level model, then replayed and compared each cycle.
module tb_pc_sequencer;

  localparam int BOOT_DELAY    = 2;
  localparam int FETCH_TIMEOUT = 15;
  localparam int COUNT_W       = 32;

  logic               clk;
  logic               reset;
  logic               imem_ack;
  logic [2:0]         instr_class;
  logic               branch_taken;
  logic               stall;
  logic [1:0]         target_lsb;
  logic               resume;
  logic               imem_req;
  logic               ir_wren;
  logic               exec_en;
  logic               pc_wren;
  logic               pc_alu_sel;
  logic               pc_next_sel;
  logic               retire;
  logic               halted;
  logic               fault;
  logic [1:0]         fault_code;
  logic [COUNT_W-1:0] instr_count;

  pc_sequencer #(
    .BOOT_DELAY(BOOT_DELAY),
    .FETCH_TIMEOUT(FETCH_TIMEOUT),
    .COUNT_W(COUNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_ack(imem_ack),
    .instr_class(instr_class),
    .branch_taken(branch_taken),
    .stall(stall),
    .target_lsb(target_lsb),
    .resume(resume),
    .imem_req(imem_req),
    .ir_wren(ir_wren),
    .exec_en(exec_en),
    .pc_wren(pc_wren),
    .pc_alu_sel(pc_alu_sel),
    .pc_next_sel(pc_next_sel),
    .retire(retire),
    .halted(halted),
    .fault(fault),
    .fault_code(fault_code),
    .instr_count(instr_count)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic               rst, ack;
    logic [2:0]         cls;
    logic               taken, stall, res;
    logic [1:0]         lsb;
    logic               req, irw, exe, pcw, alu, nxt, ret, hlt, flt;
    logic [1:0]         code;
    logic [COUNT_W-1:0] cnt;
    logic               chk, sel_chk;
  } cyc_t;

  cyc_t               q[$];
  logic [COUNT_W-1:0] m_count;
  logic               m_fault;
  logic [1:0]         m_code;

  int n_assert = 0;
  int n_fail   = 0;
  int rel_cyc, first_req, pcw_cnt, exe_cnt, hlt_cnt, req_cnt;
  logic nxt_at_wr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] sel_rule(input logic [2:0] cls, input logic taken);
    case (cls)
      3'd1:    sel_rule = taken ? 2'b00 : 2'b10;
      3'd2:    sel_rule = 2'b00;
      3'd3:    sel_rule = 2'b11;
      default: sel_rule = 2'b10;
    endcase
  endfunction

  function automatic cyc_t idle();
    cyc_t c;
    c.rst = 1'b0; c.ack = 1'b0; c.cls = 3'd0; c.taken = 1'b0; c.stall = 1'b0;
    c.res = 1'b0; c.lsb = 2'd0;
    c.req = 1'b0; c.irw = 1'b0; c.exe = 1'b0; c.pcw = 1'b0; c.alu = 1'b0;
    c.nxt = 1'b0; c.ret = 1'b0; c.hlt = 1'b0;
    c.flt = m_fault; c.code = m_code; c.cnt = m_count;
    c.chk = 1'b1; c.sel_chk = 1'b0;
    return c;
  endfunction

  // First reset cycle still shows the pre-reset state, so it is not compared.
  task automatic g_reset();
    cyc_t c;
    c = idle(); c.rst = 1'b1; c.chk = 1'b0; q.push_back(c);
    m_count = '0; m_fault = 1'b0; m_code = 2'd0;
    c = idle(); c.rst = 1'b1; c.ack = 1'b1; c.res = 1'b1; q.push_back(c);
  endtask

  task automatic g_boot();
    cyc_t c;
    for (int i = 0; i < BOOT_DELAY; i++) begin
      c = idle(); q.push_back(c);
    end
  endtask

  task automatic g_fault(input logic [1:0] code, input int n);
    cyc_t c;
    m_fault = 1'b1;
    m_code  = code;
    for (int i = 0; i < n; i++) begin
      c = idle(); c.ack = 1'b1; c.cls = 3'd3; c.res = 1'b1; c.taken = 1'b1;
      q.push_back(c);
    end
  endtask

  task automatic g_tail();
    cyc_t c;
    c = idle(); c.req = 1'b1; q.push_back(c);
  endtask

  task automatic g_instr(input int wait_n, input logic [2:0] cls, input int stall_n,
                         input logic taken, input logic [1:0] lsb, input int halt_wait);
    cyc_t c;
    logic [1:0] s;
    for (int i = 0; i < wait_n && i < FETCH_TIMEOUT; i++) begin
      c = idle(); c.req = 1'b1; q.push_back(c);
    end
    if (wait_n >= FETCH_TIMEOUT) begin
      g_fault(2'd3, 4);
      return;
    end
    c = idle(); c.req = 1'b1; c.ack = 1'b1; c.irw = 1'b1; q.push_back(c);
    c = idle(); c.cls = cls;
    if (cls >= 3'd5) begin
      q.push_back(c);
      g_fault(2'd1, 6);
      return;
    end
    if (cls == 3'd4) begin
      c.ret = 1'b1; q.push_back(c);
      m_count = m_count + 1'b1;
      for (int i = 0; i < halt_wait; i++) begin
        c = idle(); c.hlt = 1'b1; q.push_back(c);
      end
      c = idle(); c.hlt = 1'b1; c.res = 1'b1; c.pcw = 1'b1; c.alu = 1'b1; c.nxt = 1'b0;
      c.sel_chk = 1'b1; q.push_back(c);
      return;
    end
    q.push_back(c);
    for (int i = 0; i < stall_n; i++) begin
      c = idle(); c.exe = 1'b1; c.stall = 1'b1; c.taken = ~taken; q.push_back(c);
    end
    c = idle(); c.exe = 1'b1; c.taken = taken; q.push_back(c);
    c = idle(); c.lsb = lsb;
    if (lsb != 2'd0) begin
      q.push_back(c);
      g_fault(2'd2, 4);
      return;
    end
    s = sel_rule(cls, taken);
    c.pcw = 1'b1; c.ret = 1'b1; c.alu = s[1]; c.nxt = s[0]; c.sel_chk = 1'b1;
    q.push_back(c);
    m_count = m_count + 1'b1;
  endtask

  task automatic run_queue();
    cyc_t c;
    rel_cyc = 0; first_req = 0; pcw_cnt = 0; exe_cnt = 0; hlt_cnt = 0; req_cnt = 0;
    nxt_at_wr = 1'b0;
    while (q.size() > 0) begin
      c = q.pop_front();
      reset = c.rst; imem_ack = c.ack; instr_class = c.cls; branch_taken = c.taken;
      stall = c.stall; target_lsb = c.lsb; resume = c.res;
      @(negedge clk);
      if (c.chk) begin
        check("cycle", 64'({imem_req, ir_wren, exec_en, pc_wren, retire, halted, fault,
                            fault_code, instr_count}),
                       64'({c.req, c.irw, c.exe, c.pcw, c.ret, c.hlt, c.flt,
                            c.code, c.cnt}));
        if (c.sel_chk)
          check("pc_sel", 64'({pc_alu_sel, pc_next_sel}), 64'({c.alu, c.nxt}));
      end
      if (!c.rst) begin
        rel_cyc++;
        if (imem_req && first_req == 0) first_req = rel_cyc;
      end
      pcw_cnt += int'(pc_wren);
      exe_cnt += int'(exec_en);
      hlt_cnt += int'(halted);
      req_cnt += int'(imem_req);
      if (pc_wren) nxt_at_wr = pc_next_sel;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    m_count = '0; m_fault = 1'b0; m_code = 2'd0;

    // three SEQ instructions, ack on the second FETCH cycle
    g_reset(); g_boot();
    for (int i = 0; i < 3; i++) g_instr(1, 3'd0, 0, 1'b0, 2'd0, 0);
    g_tail();
    run_queue();
    check("first_req_cycle", 64'(first_req), 64'(3));
    check("seq_pc_writes", 64'(pcw_cnt), 64'(3));
    check("seq_count", 64'(instr_count), 64'(3));

    // branch taken then not taken
    g_reset(); g_boot();
    g_instr(0, 3'd1, 0, 1'b1, 2'd0, 0);
    g_instr(2, 3'd1, 1, 1'b0, 2'd0, 0);
    g_tail();
    run_queue();
    check("branch_pc_writes", 64'(pcw_cnt), 64'(2));

    // JALR with four stall cycles
    g_reset(); g_boot();
    g_instr(0, 3'd3, 4, 1'b1, 2'd0, 0);
    g_tail();
    run_queue();
    check("jalr_exec_cycles", 64'(exe_cnt), 64'(5));
    check("jalr_pc_writes", 64'(pcw_cnt), 64'(1));
    check("jalr_next_sel", 64'(nxt_at_wr), 64'(1));

    // illegal class after one SEQ, then reset out of FAULT
    g_reset(); g_boot();
    g_instr(0, 3'd0, 0, 1'b0, 2'd0, 0);
    g_instr(0, 3'd6, 0, 1'b0, 2'd0, 0);
    run_queue();
    check("illegal_code", 64'(fault_code), 64'(1));
    check("illegal_pc_writes", 64'(pcw_cnt), 64'(1));
    g_reset();
    run_queue();
    check("post_fault_count", 64'(instr_count), 64'(0));
    check("post_fault_flag", 64'(fault), 64'(0));

    // fetch timeout
    g_reset(); g_boot();
    g_instr(15, 3'd0, 0, 1'b0, 2'd0, 0);
    run_queue();
    check("timeout_code", 64'(fault_code), 64'(3));
    check("timeout_req_cycles", 64'(req_cnt), 64'(15));

    // ack on the 15th FETCH cycle wins over the timeout
    g_reset(); g_boot();
    g_instr(14, 3'd0, 0, 1'b0, 2'd0, 0);
    g_tail();
    run_queue();
    check("late_ack_pc_writes", 64'(pcw_cnt), 64'(1));
    check("late_ack_fault", 64'(fault), 64'(0));

    // HALT, resume after 10 cycles, then one SEQ
    g_reset(); g_boot();
    g_instr(0, 3'd4, 0, 1'b0, 2'd0, 10);
    g_instr(0, 3'd0, 0, 1'b0, 2'd0, 0);
    g_tail();
    run_queue();
    check("halt_cycles", 64'(hlt_cnt), 64'(11));
    check("halt_pc_writes", 64'(pcw_cnt), 64'(2));
    check("halt_count", 64'(instr_count), 64'(2));

    // JAL with misaligned target
    g_reset(); g_boot();
    g_instr(0, 3'd2, 0, 1'b0, 2'd2, 0);
    run_queue();
    check("misalign_code", 64'(fault_code), 64'(2));
    check("misalign_pc_writes", 64'(pcw_cnt), 64'(0));
    check("misalign_count", 64'(instr_count), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
